program_counter_fetch: RTL and testbench

PROGRAM_COUNTER_FETCH -- requirements
Module: program_counter_fetch

---
 rtl/program_counter_fetch_pkg.sv | 20 ++
 rtl/program_counter_fetch_if.sv | 13 +
 rtl/program_counter_fetch_wait_timer.sv | 31 +++
 rtl/program_counter_fetch.sv | 108 ++++++++++
 tb/tb_program_counter_fetch.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/program_counter_fetch_pkg.sv
// Shared types and widths for the instruction fetch unit.
package program_counter_fetch_pkg;

  localparam int unsigned PC_WIDTH       = 32;
  localparam int unsigned INSTR_WIDTH    = 32;
  localparam int unsigned WAIT_CNT_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    HOLD,
    HALT,
    ERROR
  } fetch_state_t;

  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] addr);
    return {addr[PC_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/program_counter_fetch_if.sv
// Instruction memory request/acknowledge bus between the fetch unit and memory.
interface program_counter_fetch_if;
  import program_counter_fetch_pkg::*;

  logic                   Imem_Req;
  logic [PC_WIDTH-1:0]    Imem_Addr;
  logic                   Imem_Ack;
  logic [INSTR_WIDTH-1:0] Imem_Data;

  modport master (output Imem_Req, Imem_Addr, input Imem_Ack, Imem_Data);
  modport slave  (input Imem_Req, Imem_Addr, output Imem_Ack, Imem_Data);

endinterface

// File: rtl/program_counter_fetch_wait_timer.sv
// Counts unacknowledged request cycles; expired flags the last permitted cycle.
module fetch_wait_timer
  import program_counter_fetch_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [WAIT_CNT_WIDTH-1:0] LAST = WAIT_CNT_WIDTH'(WAIT_LIMIT - 1);

  logic [WAIT_CNT_WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (count_en) begin
      count_q <= count_q + WAIT_CNT_WIDTH'(1);
    end
  end

  // Asserted during the cycle whose missing ack brings the count to WAIT_LIMIT.
  assign expired = count_en && (count_q == LAST);

endmodule

// File: rtl/program_counter_fetch.sv
// Program counter and instruction fetch FSM (IDLE/REQ/HOLD/HALT/ERROR).
// Optional build macro PC_ALIGN_CHECK_EN: misaligned New_PC in HOLD raises Fetch_Error.
module program_counter_fetch
  import program_counter_fetch_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned         WAIT_LIMIT = 16
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [PC_WIDTH-1:0]    New_PC,
  input  logic                   Stall,
  input  logic                   Halt_Req,
  program_counter_fetch_if.master imem,
  output logic [PC_WIDTH-1:0]    PC,
  output logic [PC_WIDTH-1:0]    PC_Plus_4,
  output logic [INSTR_WIDTH-1:0] Instruction,
  output logic                   Instr_Valid,
  output logic                   Halted,
  output logic                   Fetch_Error
);

  fetch_state_t           state;
  logic [PC_WIDTH-1:0]    pc_q;
  logic [INSTR_WIDTH-1:0] instr_q;
  logic                   valid_q;
  logic                   req_q;
  logic                   halted_q;
  logic                   error_q;
  logic                   timeout;
  logic                   align_fault;

`ifdef PC_ALIGN_CHECK_EN
  assign align_fault = (New_PC[1:0] != 2'b00);
`else
  assign align_fault = 1'b0;
`endif

  fetch_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .clear    (state != REQ),
    .count_en ((state == REQ) && !imem.Imem_Ack),
    .expired  (timeout)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      req_q    <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_q <= 1'b1;
          state <= REQ;
        end
        REQ: begin
          // Ack takes priority over a simultaneous timeout.
          if (imem.Imem_Ack) begin
            instr_q <= imem.Imem_Data;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state   <= HOLD;
          end else if (timeout) begin
            req_q   <= 1'b0;
            error_q <= 1'b1;
            state   <= ERROR;
          end
        end
        HOLD: begin
          if (!Stall) begin
            valid_q <= 1'b0;
            if (align_fault) begin
              error_q <= 1'b1;
              state   <= ERROR;
            end else begin
              pc_q <= word_align(New_PC);
              if (Halt_Req) begin
                halted_q <= 1'b1;
                state    <= HALT;
              end else begin
                req_q <= 1'b1;
                state <= REQ;
              end
            end
          end
        end
        HALT, ERROR: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign imem.Imem_Req  = req_q;
  assign imem.Imem_Addr = pc_q;
  assign PC             = pc_q;
  assign PC_Plus_4      = pc_q + PC_WIDTH'(4);
  assign Instruction    = instr_q;
  assign Instr_Valid    = valid_q;
  assign Halted         = halted_q;
  assign Fetch_Error    = error_q;

endmodule

// File: tb/tb_program_counter_fetch.sv
// Self-checking bench for program_counter_fetch: directed table, corner sequences, random vs. model.
module tb_program_counter_fetch;

  localparam int unsigned WL  = 4;
  localparam logic [31:0] RPC = 32'h0000_0000;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [31:0] New_PC = '0;
  logic        Stall = 1'b0;
  logic        Halt_Req = 1'b0;
  logic [31:0] PC, PC_Plus_4, Instruction;
  logic        Instr_Valid, Halted, Fetch_Error;

  program_counter_fetch_if imem_if ();

  program_counter_fetch #(.RESET_PC(RPC), .WAIT_LIMIT(WL)) dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .New_PC      (New_PC),
    .Stall       (Stall),
    .Halt_Req    (Halt_Req),
    .imem        (imem_if),
    .PC          (PC),
    .PC_Plus_4   (PC_Plus_4),
    .Instruction (Instruction),
    .Instr_Valid (Instr_Valid),
    .Halted      (Halted),
    .Fetch_Error (Fetch_Error)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference: what the fetch unit is doing, not how it encodes it.
  bit          m_started, m_fetching, m_holding, m_halted, m_errored;
  int unsigned m_waited;
  logic [31:0] m_pc, m_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 0; m_fetching = 0; m_holding = 0; m_halted = 0; m_errored = 0;
    m_waited = 0; m_pc = RPC; m_instr = '0;
  endtask

  task automatic model_step();
    if (!m_started) begin
      m_started = 1; m_fetching = 1; m_waited = 0;
    end else if (m_fetching) begin
      if (imem_if.Imem_Ack) begin
        m_instr = imem_if.Imem_Data; m_fetching = 0; m_holding = 1;
      end else begin
        m_waited++;
        if (m_waited >= WL) begin m_fetching = 0; m_errored = 1; end
      end
    end else if (m_holding && !Stall) begin
      m_holding = 0;
      if (ALIGN_CHK && (New_PC % 4 != 0)) m_errored = 1;
      else begin
        m_pc = New_PC - (New_PC % 4);
        if (Halt_Req) m_halted = 1;
        else begin m_fetching = 1; m_waited = 0; end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".req"},    imem_if.Imem_Req, m_fetching);
    chk({tag, ".addr"},   imem_if.Imem_Addr, m_pc);
    chk({tag, ".pc"},     PC, m_pc);
    chk({tag, ".pc4"},    PC_Plus_4, m_pc + 32'd4);
    chk({tag, ".instr"},  Instruction, m_instr);
    chk({tag, ".valid"},  Instr_Valid, m_holding);
    chk({tag, ".halted"}, Halted, m_halted);
    chk({tag, ".err"},    Fetch_Error, m_errored);
  endtask

  task automatic drive(input logic st, input logic hr, input logic [31:0] np,
                       input logic ak, input logic [31:0] dt);
    Stall = st; Halt_Req = hr; New_PC = np;
    imem_if.Imem_Ack = ak; imem_if.Imem_Data = dt;
  endtask

  task automatic cycle();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
  endtask

  // Reset is asserted mid-cycle so its effect must be asynchronous.
  task automatic do_reset(input string tag);
    @(negedge Clk);
    #2;
    Rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    model_reset();
    chk({tag, ".rst_pc"},    PC, RPC);
    chk({tag, ".rst_req"},   imem_if.Imem_Req, 1'b0);
    chk({tag, ".rst_valid"}, Instr_Valid, 1'b0);
    chk({tag, ".rst_instr"}, Instruction, 32'h0);
    chk({tag, ".rst_flags"}, {Halted, Fetch_Error}, 2'b00);
    @(negedge Clk);
    Rst_n = 1'b1;
  endtask

  typedef struct {
    logic        stall, halt;
    logic [31:0] new_pc;
    logic        ack;
    logic [31:0] data;
    logic        req;
    logic [31:0] pc, instr;
    logic        valid, halted, err;
  } vec_t;

  vec_t tbl[11];

  initial begin
    imem_if.Imem_Ack  = 1'b0;
    imem_if.Imem_Data = '0;
    model_reset();

    tbl[0]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 32'h0,  32'h0,         1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         1'b1, 32'h0,  32'h0,         1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h2002_0005, 1'b0, 32'h0,  32'h2002_0005, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h40,  1'b0, 32'h0,         1'b0, 32'h0,  32'h2002_0005, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h40,  1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,  32'h2002_0005, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h40,  1'b0, 32'h0,         1'b0, 32'h0,  32'h2002_0005, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 32'h40,  1'b0, 32'h0,         1'b1, 32'h40, 32'h2002_0005, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 32'h40,  1'b1, 32'hDEAD_BEEF, 1'b0, 32'h40, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 32'h8,   1'b0, 32'h0,         1'b0, 32'h8,  32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 32'h100, 1'b1, 32'h1111_1111, 1'b0, 32'h8,  32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h100, 1'b1, 32'h2222_2222, 1'b0, 32'h8,  32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0};

    // Directed table: first fetch, stalled hold, jump, halt.
    do_reset("tbl");
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].stall, tbl[i].halt, tbl[i].new_pc, tbl[i].ack, tbl[i].data);
      cycle();
      chk($sformatf("tbl%0d.req", i),    imem_if.Imem_Req, tbl[i].req);
      chk($sformatf("tbl%0d.addr", i),   imem_if.Imem_Addr, tbl[i].pc);
      chk($sformatf("tbl%0d.pc4", i),    PC_Plus_4, tbl[i].pc + 32'd4);
      chk($sformatf("tbl%0d.instr", i),  Instruction, tbl[i].instr);
      chk($sformatf("tbl%0d.valid", i),  Instr_Valid, tbl[i].valid);
      chk($sformatf("tbl%0d.halted", i), Halted, tbl[i].halted);
      chk($sformatf("tbl%0d.err", i),    Fetch_Error, tbl[i].err);
    end

    // Timeout: WAIT_LIMIT request cycles without ack.
    do_reset("tmo");
    cycle();
    for (int k = 1; k < int'(WL); k++) begin
      cycle();
      chk($sformatf("tmo.req%0d", k), imem_if.Imem_Req, 1'b1);
      chk($sformatf("tmo.err%0d", k), Fetch_Error, 1'b0);
    end
    cycle();
    chk("tmo.err", Fetch_Error, 1'b1);
    chk("tmo.req_off", imem_if.Imem_Req, 1'b0);
    drive(1'b0, 1'b0, 32'h40, 1'b1, 32'h5555_5555);
    cycle();
    chk("tmo.stuck_err", Fetch_Error, 1'b1);
    chk("tmo.stuck_req", imem_if.Imem_Req, 1'b0);
    chk("tmo.no_valid", Instr_Valid, 1'b0);

    // Ack on the final permitted cycle wins over timeout.
    do_reset("last");
    cycle();
    for (int k = 1; k < int'(WL); k++) cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    cycle();
    chk("last.valid", Instr_Valid, 1'b1);
    chk("last.err", Fetch_Error, 1'b0);
    chk("last.instr", Instruction, 32'h1234_5678);

    // Misaligned jump target.
    drive(1'b0, 1'b0, 32'h0000_0042, 1'b0, 32'h0);
    cycle();
    if (ALIGN_CHK) begin
      chk("align.err", Fetch_Error, 1'b1);
      chk("align.pc", PC, 32'h0);
    end else begin
      chk("align.err", Fetch_Error, 1'b0);
      chk("align.pc", PC, 32'h0000_0040);
    end

    // PC_Plus_4 wraps at the top of the address space; then reset mid-REQ with a late ack.
    do_reset("wrap");
    cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h0BAD_F00D);
    cycle();
    drive(1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    cycle();
    chk("wrap.pc", PC, 32'hFFFF_FFFC);
    chk("wrap.pc4", PC_Plus_4, 32'h0000_0000);
    chk("wrap.err", Fetch_Error, 1'b0);
    chk("wrap.req", imem_if.Imem_Req, 1'b1);
    do_reset("midreq");
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hAAAA_AAAA);
    cycle();
    chk("midreq.valid", Instr_Valid, 1'b0);
    chk("midreq.instr", Instruction, 32'h0);
    chk("midreq.pc", PC, RPC);
    chk("midreq.req", imem_if.Imem_Req, 1'b1);
    cycle();
    chk("midreq.accept", Instr_Valid, 1'b1);
    chk("midreq.data", Instruction, 32'hAAAA_AAAA);

    // Random episodes against the reference model.
    for (int ep = 0; ep < 25; ep++) begin
      do_reset($sformatf("rnd%0d", ep));
      for (int c = 0; c < 40; c++) begin
        logic [31:0] np;
        np = $urandom;
        if ($urandom_range(3) != 0) np[1:0] = 2'b00;
        drive(1'($urandom_range(1)), 1'($urandom_range(9) == 0), np,
              1'($urandom_range(1)), $urandom);
        cycle();
        check_model($sformatf("rnd%0d.%0d", ep, c));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
